multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32 and set the register, ALU and data-bus width.
REQ-002 Parameter ADDR_WIDTH SHALL default to 32 and set the PC and memory-address width.
REQ-003 Parameter RESET_PC SHALL default to 0 and set the PC value after reset.
REQ-004 Clock and reset: clk input 1, single clock, rising edge; rst_n input 1, asynchronous, active-low.
REQ-005 Instruction-memory ports: imem_req output 1, fetch request; imem_addr output ADDR_WIDTH, fetch address; imem_ready input 1, fetch complete; imem_rdata input 32, instruction word.
REQ-006 Data-memory ports: dmem_req output 1, access request; dmem_we output 1, write when 1; dmem_addr output ADDR_WIDTH, address; dmem_wdata output DATA_WIDTH, store data; dmem_ready input 1, access complete; dmem_rdata input DATA_WIDTH, load data.
REQ-007 Status ports: a0 output DATA_WIDTH, live value of x10; halted output 1, core stopped on an illegal instruction; state_o output 3, current FSM state.

Function
REQ-008 The core SHALL execute ADD, SUB, ADDI, LW, SW, BEQ, BNE, JAL with RV32I encodings; the immediate SHALL be sign-extended to DATA_WIDTH.
REQ-009 The register file SHALL hold 32 x DATA_WIDTH registers; x0 SHALL read 0 and ignore writes.
REQ-010 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-011 FETCH: imem_req=1 with imem_addr=PC, both held stable until the imem_ready cycle; on imem_ready, capture imem_rdata into IR and go to DECODE.
REQ-012 DECODE (1 cycle): latch rs1 and rs2 values and the immediate into A, B and IMM; on an unsupported opcode, go to HALT; otherwise go to EXEC.
REQ-013 EXEC (1 cycle), by instruction class:
  - ADD/SUB/ADDI: latch the result, modulo 2^DATA_WIDTH, into ALUR; go to WB.
  - LW/SW: ALUR = A + IMM; go to MEM.
  - BEQ/BNE: PC = PC + IMM if taken, else PC + 4; go to FETCH.
  - JAL: ALUR = PC + 4; PC = PC + IMM; go to WB.
REQ-014 MEM: dmem_req=1, dmem_addr=ALUR, dmem_we=1 for SW, dmem_wdata=B, all held until the dmem_ready cycle. On dmem_ready: LW latches dmem_rdata into MDR and goes to WB; SW sets PC = PC + 4 and goes to FETCH.
REQ-015 WB (1 cycle): write MDR (LW) or ALUR (others) to rd; PC = PC + 4 except JAL; go to FETCH.
REQ-016 With zero-wait memories, latency SHALL be: ALU ops 4 cycles, branches 3, JAL 4, SW 4, LW 5; each wait cycle on imem_ready or dmem_ready SHALL add exactly one cycle.
REQ-017 imem_req and dmem_req SHALL never be asserted in the same cycle, and SHALL be 0 outside FETCH and MEM respectively.
REQ-018 A ready input that is high while its request is low SHALL be ignored.
REQ-019 PC arithmetic SHALL wrap modulo 2^ADDR_WIDTH, and the two PC LSBs SHALL be forced to 0 on every PC update.
REQ-020 HALT SHALL be terminal until reset: halted=1, no requests, no register or PC change.
REQ-021 Bits of A+IMM above ADDR_WIDTH SHALL be truncated for dmem_addr.

Reset
REQ-022 While rst_n=0, asynchronously: PC=RESET_PC, state=FETCH, IR=0, A=B=IMM=ALUR=MDR=0, all registers=0, imem_req=dmem_req=dmem_we=0, halted=0, a0=0.
REQ-023 After rst_n rises, imem_req SHALL assert on the first rising clk edge.
REQ-024 Reset asserted mid-transaction (FETCH or MEM waiting) SHALL abandon the access with no register write.

Verification
REQ-025 Zero-wait memories; program ADDI x10,x0,5 -> a0=5 on the fourth rising edge after reset release; the next imem_addr is RESET_PC+4.
REQ-026 x1=3, x2=3; BEQ x1,x2,+8 at PC 0x10 -> next fetch at 0x18; BNE with the same operands -> next fetch at 0x14.
REQ-027 SW x10,4(x0) with x10=0x2A, dmem_ready delayed 3 cycles -> dmem_addr=4, dmem_wdata=0x2A, dmem_we=1 held for 4 cycles; then LW x11,4(x0) -> x11=0x2A.
REQ-028 ADDI x0,x0,7 -> x0 still reads 0; ADD x5 = 0xFFFFFFFF + 1 -> x5=0 (wrap).
REQ-029 Instruction 0xFFFFFFFF -> HALT after DECODE; halted=1; no further imem_req for 20 cycles.
REQ-030 rst_n pulsed low while in MEM with dmem_ready low -> dmem_req=0 immediately and PC=RESET_PC; the load target register stays 0.

Source files
------------

// File: rtl/multicycle_core.sv
// Multicycle RV32I subset core (ADD, SUB, ADDI, LW, SW, BEQ, BNE, JAL).
// Each instruction moves through FETCH, DECODE, EXEC, optionally MEM, and WB.
// An illegal instruction parks the core in HALT until reset.
//
// Memory handshake: a request output is high for the entire access, and
// address/data/we stay stable throughout. The access completes on the first
// rising edge at which the matching ready input is high. A ready input that
// is high while its request is low has no effect.
module multicycle_core #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  halted,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state_r, state_nx;

  logic [ADDR_WIDTH-1:0] pc_r;
  logic [31:0]           ir_r;
  logic [DATA_WIDTH-1:0] a_r, b_r, imm_r, alur_r, mdr_r;
  logic [DATA_WIDTH-1:0] regs [0:31];

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir_r[6:0];
  assign rd     = ir_r[11:7];
  assign funct3 = ir_r[14:12];
  assign rs1    = ir_r[19:15];
  assign rs2    = ir_r[24:20];
  assign funct7 = ir_r[31:25];

  logic                  is_add, is_sub, is_addi, is_lw, is_sw, is_beq, is_bne, is_jal;
  logic                  legal;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm_ext;

  // Decode the instruction class and assemble the raw immediate for its format
  always_comb begin
    is_add  = 1'b0;
    is_sub  = 1'b0;
    is_addi = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jal  = 1'b0;
    imm32   = '0;
    case (opcode)
      7'b0110011: begin
        is_add = (funct3 == 3'b000) && (funct7 == 7'b0000000);
        is_sub = (funct3 == 3'b000) && (funct7 == 7'b0100000);
      end
      7'b0010011: begin
        is_addi = (funct3 == 3'b000);
        imm32   = {{20{ir_r[31]}}, ir_r[31:20]};
      end
      7'b0000011: begin
        is_lw = (funct3 == 3'b010);
        imm32 = {{20{ir_r[31]}}, ir_r[31:20]};
      end
      7'b0100011: begin
        is_sw = (funct3 == 3'b010);
        imm32 = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
      end
      7'b1100011: begin
        is_beq = (funct3 == 3'b000);
        is_bne = (funct3 == 3'b001);
        imm32  = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
      end
      7'b1101111: begin
        is_jal = 1'b1;
        imm32  = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign legal   = is_add | is_sub | is_addi | is_lw | is_sw | is_beq | is_bne | is_jal;
  assign imm_ext = DATA_WIDTH'($signed(imm32));

  // Datapath helpers; PC results always have their two LSBs cleared
  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] p);
    return {p[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  logic [DATA_WIDTH-1:0] alu_res, ls_addr;
  logic [ADDR_WIDTH-1:0] pc_plus4, pc_imm;
  logic                  br_taken;

  assign alu_res  = is_sub ? (a_r - b_r) : (a_r + (is_addi ? imm_r : b_r));
  assign ls_addr  = a_r + imm_r;
  assign pc_plus4 = pc_r + ADDR_WIDTH'(4);
  assign pc_imm   = pc_r + ADDR_WIDTH'($signed(imm_r));
  assign br_taken = is_beq ? (a_r == b_r) : (a_r != b_r);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_FETCH;
    else        state_r <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_FETCH:  if (imem_ready) state_nx = S_DECODE;
      S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_lw || is_sw)        state_nx = S_MEM;
        else if (is_beq || is_bne) state_nx = S_FETCH;
        else                       state_nx = S_WB;
      end
      S_MEM:    if (dmem_ready) state_nx = is_lw ? S_WB : S_FETCH;
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_FETCH;
    endcase
  end

  // Outputs decoded from the current state; the fetch request stays low while reset is held
  always_comb begin
    imem_req = rst_n && (state_r == S_FETCH);
    dmem_req = (state_r == S_MEM);
    dmem_we  = (state_r == S_MEM) && is_sw;
    halted   = (state_r == S_HALT);
  end

  assign imem_addr  = pc_r;
  assign dmem_addr  = ADDR_WIDTH'(alur_r);
  assign dmem_wdata = b_r;
  assign a0         = regs[10];
  assign state_o    = state_r;

  // Datapath registers, register file and PC, updated per state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r   <= RESET_PC;
      ir_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      imm_r  <= '0;
      alur_r <= '0;
      mdr_r  <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state_r)
        S_FETCH: if (imem_ready) ir_r <= imem_rdata;
        S_DECODE: begin
          a_r   <= regs[rs1];
          b_r   <= regs[rs2];
          imm_r <= imm_ext;
        end
        S_EXEC: begin
          if (is_add || is_sub || is_addi) begin
            alur_r <= alu_res;
          end else if (is_lw || is_sw) begin
            alur_r <= ls_addr;
          end else if (is_beq || is_bne) begin
            pc_r <= align_pc(br_taken ? pc_imm : pc_plus4);
          end else if (is_jal) begin
            alur_r <= DATA_WIDTH'(pc_plus4);
            pc_r   <= align_pc(pc_imm);
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (is_lw) mdr_r <= dmem_rdata;
            else       pc_r  <= align_pc(pc_plus4);
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs[rd] <= is_lw ? mdr_r : alur_r;
          if (!is_jal)    pc_r     <= align_pc(pc_plus4);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Testbench for multicycle_core: instruction and data memory responders with
// configurable wait states, a store scoreboard, a fetch log for latency checks,
// a table of ALU vectors and hand-written multi-cycle sequences.
module tb_multicycle_core;

  localparam logic [31:0] ILL = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, a0;
  logic [2:0]  state_o;

  multicycle_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .a0         (a0),
    .halted     (halted),
    .state_o    (state_o)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial forever begin
    #5 clk = 1'b1;
    cyc++;
    #5 clk = 1'b0;
  end

  // ---------------- shared state ----------------
  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  int          imem_wmin = 0, imem_wmax = 0, dmem_wmin = 0, dmem_wmax = 0;
  bit          spurious = 1'b0;
  logic [63:0] exp_q[$];       // {addr, data} of each expected store
  logic [31:0] f_addr[$];      // accepted fetch addresses
  int          f_cyc[$];       // cycle number of each accepted fetch
  int          f_base = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] instr;
    int          rd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'b010, 5'(rd), 7'h03};
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] sub(input int rd, input int rs1, input int rs2);
    return {7'h20, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] jal(input int rd, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  // ---------------- memory responders + store scoreboard ----------------
  initial begin
    int          icnt, iw, dcnt, dw;
    logic [63:0] e;
    icnt = 0; iw = 0; dcnt = 0; dw = 0;
    imem_ready = 1'b0; imem_rdata = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req) begin
        if (icnt == 0) iw = $urandom_range(imem_wmax, imem_wmin);
        if (icnt >= iw) begin
          imem_ready = 1'b1;
          imem_rdata = imem[imem_addr[9:2]];
          f_addr.push_back(imem_addr);
          f_cyc.push_back(cyc);
        end else begin
          imem_ready = 1'b0;
          imem_rdata = $urandom;
          icnt++;
        end
      end else begin
        icnt = 0;
        imem_ready = spurious;
        imem_rdata = $urandom;
      end
      if (rst_n && dmem_req) begin
        if (dcnt == 0) dw = $urandom_range(dmem_wmax, dmem_wmin);
        if (dcnt >= dw) begin
          dmem_ready = 1'b1;
          if (dmem_we) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_store addr=%h data=%h expected=none", dmem_addr, dmem_wdata);
            end else begin
              e = exp_q.pop_front();
              check("store_addr", dmem_addr, e[63:32]);
              check("store_data", dmem_wdata, e[31:0]);
            end
            dmem[dmem_addr[9:2]] = dmem_wdata;
          end else begin
            dmem_rdata = dmem[dmem_addr[9:2]];
          end
        end else begin
          dmem_ready = 1'b0;
          dmem_rdata = $urandom;
          dcnt++;
        end
      end else begin
        dcnt = 0;
        dmem_ready = spurious;
        dmem_rdata = $urandom;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = ILL;
  endtask

  task automatic assert_reset(input bit chk);
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check("rst_imem_req", imem_req, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_dmem_we", dmem_we, 0);
      check("rst_halted", halted, 0);
      check("rst_a0", a0, 0);
      check("rst_state", state_o, 0);
      check("rst_pc", imem_addr, 0);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    f_base = f_addr.size();
  endtask

  task automatic run_until_halt(input string name);
    int n, reqs;
    n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, halted, 1);
    check({name, "_halt_state"}, state_o, 5);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req) reqs++;
    end
    check({name, "_reqs_in_halt"}, reqs, 0);
    check({name, "_stores_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Checks the k-th fetch of the current run: its address and the cycle gap to fetch k-1
  task automatic check_fetch(input string name, input int k, input logic [31:0] addr, input int delta);
    if (f_addr.size() <= f_base + k) begin
      checks++;
      errors++;
      $display("FAIL %s actual=missing_fetch expected=%h", name, addr);
    end else begin
      check({name, "_addr"}, f_addr[f_base + k], addr);
      check({name, "_latency"}, f_cyc[f_base + k] - f_cyc[f_base + k - 1], delta);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[11];
    int   n, hold;

    vecs[0]  = '{addi(1, 0, 3),     1,  32'h0000_0003};
    vecs[1]  = '{addi(2, 0, -5),    2,  32'hFFFF_FFFB};
    vecs[2]  = '{addi(3, 0, -1),    3,  32'hFFFF_FFFF};
    vecs[3]  = '{addi(4, 0, 1),     4,  32'h0000_0001};
    vecs[4]  = '{add(5, 3, 4),      5,  32'h0000_0000};
    vecs[5]  = '{sub(6, 1, 4),      6,  32'h0000_0002};
    vecs[6]  = '{sub(7, 4, 1),      7,  32'hFFFF_FFFE};
    vecs[7]  = '{addi(0, 0, 7),     0,  32'h0000_0000};
    vecs[8]  = '{addi(8, 0, -2048), 8,  32'hFFFF_F800};
    vecs[9]  = '{addi(9, 0, 2047),  9,  32'h0000_07FF};
    vecs[10] = '{add(10, 9, 2),     10, 32'h0000_07FA};

    for (int i = 0; i < 256; i++) dmem[i] = '0;

    // ADDI x10 writes a0 on the fourth edge after reset release
    clear_imem();
    imem[0] = addi(10, 0, 5);
    assert_reset(1'b1);
    release_reset();
    repeat (3) @(posedge clk);
    #1 check("a0_before_wb", a0, 0);
    @(posedge clk);
    #1;
    check("a0_after_4_edges", a0, 5);
    check("next_fetch_addr", imem_addr, 4);
    check("next_fetch_req", imem_req, 1);
    run_until_halt("addi");

    // ALU vector table, random wait states, ready pulses outside requests
    clear_imem();
    assert_reset(1'b1);
    for (int i = 0; i < 11; i++) begin
      imem[2*i]     = vecs[i].instr;
      imem[2*i + 1] = sw(vecs[i].rd, 0, 'h100 + 4*i);
      exp_q.push_back({32'h100 + 32'(4*i), vecs[i].exp});
    end
    imem_wmin = 0; imem_wmax = 2; dmem_wmin = 0; dmem_wmax = 2;
    spurious = 1'b1;
    release_reset();
    run_until_halt("table");
    check("table_a0", a0, 32'h7FA);
    spurious = 1'b0;
    imem_wmax = 0; dmem_wmax = 0;

    // BEQ (taken) and BNE (not taken) with equal operands at PC 0x10
    for (int k = 0; k < 2; k++) begin
      clear_imem();
      assert_reset(1'b0);
      imem[0] = addi(1, 0, 3);
      imem[1] = addi(2, 0, 3);
      imem[2] = addi(0, 0, 0);
      imem[3] = addi(0, 0, 0);
      imem[4] = br((k == 0) ? 3'b000 : 3'b001, 1, 2, 8);
      imem[5] = sw(1, 0, 'h60);
      imem[6] = sw(2, 0, 'h64);
      if (k == 1) exp_q.push_back({32'h60, 32'd3});
      exp_q.push_back({32'h64, 32'd3});
      release_reset();
      run_until_halt((k == 0) ? "beq" : "bne");
      check_fetch((k == 0) ? "beq_next" : "bne_next", 5, (k == 0) ? 32'h18 : 32'h14, 3);
    end

    // JAL x10,+10: link = 4, target 0x0A is aligned down to 0x08
    clear_imem();
    assert_reset(1'b0);
    imem[0] = jal(10, 10);
    imem[2] = sw(10, 0, 'h40);
    exp_q.push_back({32'h40, 32'd4});
    release_reset();
    run_until_halt("jal");
    check_fetch("jal_target", 1, 32'h8, 4);
    check("jal_a0", a0, 4);

    // SW then LW through a data memory with 3 wait cycles
    clear_imem();
    assert_reset(1'b0);
    imem[0] = addi(10, 0, 'h2A);
    imem[1] = sw(10, 0, 4);
    imem[2] = lw(11, 0, 4);
    imem[3] = sw(11, 0, 8);
    exp_q.push_back({32'h4, 32'h2A});
    exp_q.push_back({32'h8, 32'h2A});
    dmem_wmin = 3; dmem_wmax = 3;
    release_reset();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dmem_req && n < 40);
    hold = 0;
    while (dmem_req && dmem_we && dmem_addr == 32'h4 && dmem_wdata == 32'h2A && hold < 20) begin
      hold++;
      @(negedge clk);
    end
    check("sw_hold_cycles", hold, 4);
    run_until_halt("sw_lw");
    check_fetch("addi_lat", 1, 32'h4, 4);
    check_fetch("sw_lat", 2, 32'h8, 7);
    check_fetch("lw_lat", 3, 32'hC, 8);
    dmem_wmin = 0; dmem_wmax = 0;

    // Reset during a stalled load abandons it; x11 stays zero
    clear_imem();
    dmem[0] = 32'h55;
    imem[0] = lw(11, 0, 0);
    assert_reset(1'b0);
    dmem_wmin = 50; dmem_wmax = 50;
    release_reset();
    n = 0;
    while (!dmem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mem_reached", dmem_req, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_dmem_req", dmem_req, 0);
    check("abort_pc", imem_addr, 0);
    check("abort_state", state_o, 0);
    dmem_wmin = 0; dmem_wmax = 0;
    imem[0] = sw(11, 0, 'h20);
    exp_q.push_back({32'h20, 32'h0});
    release_reset();
    run_until_halt("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
